alu_seq: RTL

//  Parametrised, registered successor of the combinational ALU. It adds a valid/ready handshake on input and output,

---
 rtl/alu_pkg.sv | 36 +++
 rtl/alu_mul_iter.sv | 75 +++++++
 rtl/alu_seq.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared types for the sequential ALU: opcodes, FSM states and NZCV flag positions.
package alu_pkg;

    typedef enum logic [2:0] {
        OP_ADD = 3'd0,
        OP_SUB = 3'd1,
        OP_CMP = 3'd2,
        OP_LSL = 3'd3,
        OP_LSR = 3'd4,
        OP_ASR = 3'd5,
        OP_AND = 3'd6,
        OP_MUL = 3'd7
    } alu_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } alu_state_e;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    function automatic logic [3:0] pack_nzcv(input logic n, input logic z, input logic c, input logic v);
        logic [3:0] f;
        f         = 4'b0000;
        f[FLAG_N] = n;
        f[FLAG_Z] = z;
        f[FLAG_C] = c;
        f[FLAG_V] = v;
        return f;
    endfunction

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative shift-add multiplier, one multiplier bit per cycle; signed operands are
// handled as magnitudes and the product is negated on the final iteration.
module alu_mul_iter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] product,
    output logic             ovf
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    logic                 busy_reg;
    logic [CNT_W-1:0]     cnt_reg;
    logic [2*WIDTH-1:0]   mcand_reg;
    logic [WIDTH-1:0]     mplier_reg;
    logic [2*WIDTH-1:0]   acc_reg;
    logic                 neg_reg;
    logic                 signed_reg;

    logic [WIDTH-1:0]     a_mag;
    logic [WIDTH-1:0]     b_mag;
    logic [2*WIDTH-1:0]   acc_next;
    logic [2*WIDTH-1:0]   full_next;
    logic [WIDTH-1:0]     hi_next;

    assign a_mag     = (is_signed && a[WIDTH-1]) ? -a : a;
    assign b_mag     = (is_signed && b[WIDTH-1]) ? -b : b;
    assign acc_next  = acc_reg + (mplier_reg[0] ? mcand_reg : '0);
    // The result is taken straight from the last accumulation so it lands in the same edge.
    assign full_next = neg_reg ? -acc_next : acc_next;
    assign hi_next   = full_next[2*WIDTH-1:WIDTH];

    assign product = full_next[WIDTH-1:0];
    assign ovf     = signed_reg ? (hi_next != {WIDTH{full_next[WIDTH-1]}}) : (hi_next != '0);
    assign done    = busy_reg && (cnt_reg == LAST);
    assign busy    = busy_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_reg   <= 1'b0;
            cnt_reg    <= '0;
            mcand_reg  <= '0;
            mplier_reg <= '0;
            acc_reg    <= '0;
            neg_reg    <= 1'b0;
            signed_reg <= 1'b0;
        end else if (start) begin
            busy_reg   <= 1'b1;
            cnt_reg    <= '0;
            mcand_reg  <= {{WIDTH{1'b0}}, a_mag};
            mplier_reg <= b_mag;
            acc_reg    <= '0;
            neg_reg    <= is_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
            signed_reg <= is_signed;
        end else if (busy_reg) begin
            acc_reg    <= acc_next;
            mcand_reg  <= mcand_reg << 1;
            mplier_reg <= mplier_reg >> 1;
            cnt_reg    <= cnt_reg + 1'b1;
            if (done) begin
                busy_reg <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/alu_seq.sv
// Registered ALU with valid/ready handshakes and an NZCV register.
// Define ALU_SEQ_MUL_EN to build the iterative multiplier; otherwise MUL returns 0 without write-back.
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = $clog2(WIDTH)
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [WIDTH-1:0] data1_i,
    input  logic [WIDTH-1:0] data2_i,
    input  alu_op_e          opcode_i,
    input  logic             signed_i,
    input  logic             set_status_i,
    output logic             valid_o,
    input  logic             ready_i,
    output logic [WIDTH-1:0] data_o,
    output logic             wr_en_o,
    output logic [3:0]       status_o
);

    localparam logic [WIDTH-1:0] WIDTH_V = WIDTH'(WIDTH);

    alu_state_e       state_reg;
    logic [WIDTH-1:0] data_reg;
    logic             wr_en_reg;
    logic             c_reg;
    logic             v_reg;
    logic             upd_reg;
    logic [3:0]       status_reg;

    logic             accept;
    logic             go_busy;
    logic             upd_ok;
    logic             mul_done;
    logic [WIDTH-1:0] mul_res;
    logic             mul_ovf;

    logic [WIDTH:0]   add_ext;
    logic [WIDTH:0]   sub_ext;
    logic [WIDTH:0]   lsl_ext;
    logic [WIDTH:0]   lsr_ext;
    logic [WIDTH:0]   asr_ext;
    logic [SHAMT_W-1:0] shamt;
    logic             shift_big;

    logic [WIDTH-1:0] alu_res;
    logic             alu_c;
    logic             alu_v;
    logic             alu_wr;

    assign accept = valid_i && (state_reg == IDLE);

`ifdef ALU_SEQ_MUL_EN
    logic mul_start;
    logic mul_busy;

    assign mul_start = accept && (opcode_i == OP_MUL) && !mul_busy;
    assign go_busy   = (opcode_i == OP_MUL);
    assign upd_ok    = set_status_i;

    alu_mul_iter #(
        .WIDTH(WIDTH)
    ) u_mul (
        .clk       (clk_i),
        .rst       (reset_i),
        .start     (mul_start),
        .is_signed (signed_i),
        .a         (data1_i),
        .b         (data2_i),
        .busy      (mul_busy),
        .done      (mul_done),
        .product   (mul_res),
        .ovf       (mul_ovf)
    );
`else
    logic unused_signed;

    assign unused_signed = signed_i;
    assign go_busy       = 1'b0;
    assign upd_ok        = set_status_i && (opcode_i != OP_MUL);
    assign mul_done      = 1'b0;
    assign mul_res       = '0;
    assign mul_ovf       = 1'b0;
`endif

    // Shifts carry one extra bit so the last bit shifted out falls out for free (0 for shamt 0).
    assign add_ext   = {1'b0, data1_i} + {1'b0, data2_i};
    assign sub_ext   = {1'b0, data1_i} + {1'b0, ~data2_i} + {{WIDTH{1'b0}}, 1'b1};
    assign shamt     = data2_i[SHAMT_W-1:0];
    assign shift_big = (data2_i >= WIDTH_V);
    assign lsl_ext   = {1'b0, data1_i} << shamt;
    assign lsr_ext   = {data1_i, 1'b0} >> shamt;
    assign asr_ext   = $signed({data1_i, 1'b0}) >>> shamt;

    always_comb begin
        alu_res = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        alu_wr  = 1'b1;
        case (opcode_i)
            OP_ADD: begin
                alu_res = add_ext[WIDTH-1:0];
                alu_c   = add_ext[WIDTH];
                alu_v   = (data1_i[WIDTH-1] == data2_i[WIDTH-1]) && (alu_res[WIDTH-1] != data1_i[WIDTH-1]);
            end
            OP_SUB, OP_CMP: begin
                alu_res = sub_ext[WIDTH-1:0];
                alu_c   = sub_ext[WIDTH];
                alu_v   = (data1_i[WIDTH-1] != data2_i[WIDTH-1]) && (alu_res[WIDTH-1] != data1_i[WIDTH-1]);
                alu_wr  = (opcode_i == OP_SUB);
            end
            // Out-of-range logical shifts report C=0; arithmetic ones replicate the sign.
            OP_LSL: begin
                alu_res = shift_big ? '0 : lsl_ext[WIDTH-1:0];
                alu_c   = shift_big ? 1'b0 : lsl_ext[WIDTH];
            end
            OP_LSR: begin
                alu_res = shift_big ? '0 : lsr_ext[WIDTH:1];
                alu_c   = shift_big ? 1'b0 : lsr_ext[0];
            end
            OP_ASR: begin
                alu_res = shift_big ? {WIDTH{data1_i[WIDTH-1]}} : asr_ext[WIDTH:1];
                alu_c   = shift_big ? data1_i[WIDTH-1] : asr_ext[0];
            end
            OP_AND: begin
                alu_res = data1_i & data2_i;
            end
            default: begin
                alu_wr = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_reg  <= IDLE;
            data_reg   <= '0;
            wr_en_reg  <= 1'b0;
            c_reg      <= 1'b0;
            v_reg      <= 1'b0;
            upd_reg    <= 1'b0;
            status_reg <= 4'b0000;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (valid_i) begin
                        upd_reg <= upd_ok;
                        if (go_busy) begin
                            state_reg <= BUSY;
                        end else begin
                            state_reg <= DONE;
                            data_reg  <= alu_res;
                            wr_en_reg <= alu_wr;
                            c_reg     <= alu_c;
                            v_reg     <= alu_v;
                        end
                    end
                end
                BUSY: begin
                    if (mul_done) begin
                        state_reg <= DONE;
                        data_reg  <= mul_res;
                        wr_en_reg <= 1'b1;
                        c_reg     <= mul_ovf;
                        v_reg     <= mul_ovf;
                    end
                end
                DONE: begin
                    if (ready_i) begin
                        state_reg <= IDLE;
                        if (upd_reg) begin
                            status_reg <= pack_nzcv(data_reg[WIDTH-1], data_reg == '0, c_reg, v_reg);
                        end
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign ready_o  = (state_reg == IDLE);
    assign valid_o  = (state_reg == DONE);
    assign data_o   = data_reg;
    assign wr_en_o  = wr_en_reg;
    assign status_o = status_reg;

endmodule
